// File: rtl/serial_subtractor.sv
// Purpose: bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, LSB first, one full-subtractor cell.
// Latency: WIDTH+1 edges from the accepting start edge to done; done is a one-cycle pulse.
// Backpressure: start is accepted only while busy=0; starts during RUN/DONE are dropped.
// Optional: define SERIAL_SUB_OVF_EN to add the Ovf (signed overflow) output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nxt;
    logic [WIDTH-1:0] r_nxt;

    // Single full-subtractor cell on the current LSBs plus the result shift-in.
    always_comb begin
        a_i    = a_sr[0];
        b_i    = b_sr[0];
        d_i    = a_i ^ b_i ^ br;
        br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        r_nxt  = r_sr >> 1;
        r_nxt[WIDTH-1] = d_i;
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Control FSM, operand/result shift registers and held outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        br    <= Bin;
                        cnt   <= '0;
                        r_sr  <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_nxt;
                    r_sr <= r_nxt;
                    if (cnt == LAST) begin
                        // Final bit: a_i/b_i/d_i are the operand and result MSBs here.
                        Diff  <= r_nxt;
                        Bout  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        Ovf   <= (a_i ^ b_i) & (a_i ^ d_i);
`endif
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
